// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Purpose  : Y86-64 style register file with two combinational read ports,
//            two synchronous write ports (E and M, M wins on collision) and a
//            per-register pending-write scoreboard for the decode stage.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            srcA/srcB           - read indices
//            valA/valB, rdyA/rdyB- read data, operand-has-no-pending-write
//            dstE/dstM, valE/valM- write indices / data (NONE_ID = no write)
//            rsv_valid, rsvE/rsvM- reservation request and target indices
//            rsv_ready           - reservation can be accepted this cycle
// Options  : REGFILE_BYPASS_EN   - when defined, same-cycle write data is
//                                  forwarded to the read ports.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_sb #(
  parameter int          DATA_W   = 64,
  parameter int          NREGS    = 16,
  parameter int          ADDR_W   = 4,
  parameter int          NONE_ID  = 15,
  parameter int          SP_ID    = 4,
  parameter logic [63:0] SP_INIT  = 64'h0,
  parameter int          MAX_PEND = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] srcA,
  input  logic [ADDR_W-1:0] srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  output logic              rdyA,
  output logic              rdyB,
  input  logic [ADDR_W-1:0] dstE,
  input  logic [ADDR_W-1:0] dstM,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsvE,
  input  logic [ADDR_W-1:0] rsvM,
  output logic              rsv_ready
);

  localparam int CNT_W = $clog2(MAX_PEND + 1);
  // Signed working width: holds pend + 2 without overflow and a negative
  // result of pend - 2.
  localparam int SW    = CNT_W + 2;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [CNT_W-1:0]  pend_q [NREGS];
  logic [CNT_W-1:0]  pend_d [NREGS];

  logic [1:0]          inc_n [NREGS];  // reservations aimed at each register
  logic [1:0]          dec_n [NREGS];  // writes aimed at each register
  logic signed [SW-1:0] net_n [NREGS]; // counter value after inc and dec
  logic signed [SW-1:0] drn_n [NREGS]; // counter value after dec only
  logic [NREGS-1:0]    over_n;

  logic dstE_en, dstM_en, rsvE_en, rsvM_en, accept;

  // Index qualifiers: NONE_ID and out-of-range indices never act.
  assign dstE_en = (int'(dstE) != NONE_ID) && (int'(dstE) < NREGS);
  assign dstM_en = (int'(dstM) != NONE_ID) && (int'(dstM) < NREGS);
  assign rsvE_en = (int'(rsvE) != NONE_ID) && (int'(rsvE) < NREGS);
  assign rsvM_en = (int'(rsvM) != NONE_ID) && (int'(rsvM) < NREGS);

  // Write data: M is applied after E so it wins on a shared destination.
  always_comb begin
    for (int i = 0; i < NREGS; i++) regs_d[i] = regs_q[i];
    if (dstE_en) regs_d[dstE] = valE;
    if (dstM_en) regs_d[dstM] = valM;
  end

  // Scoreboard: net change per register, overflow check and next state.
  // rsv_ready assumes the request is taken, so it never looks at rsv_valid.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      inc_n[i] = 2'(rsvE_en && (int'(rsvE) == i)) + 2'(rsvM_en && (int'(rsvM) == i));
      dec_n[i] = 2'(dstE_en && (int'(dstE) == i)) + 2'(dstM_en && (int'(dstM) == i));
      net_n[i] = $signed({2'b00, pend_q[i]}) + $signed({{CNT_W{1'b0}}, inc_n[i]})
               - $signed({{CNT_W{1'b0}}, dec_n[i]});
      drn_n[i] = $signed({2'b00, pend_q[i]}) - $signed({{CNT_W{1'b0}}, dec_n[i]});
      over_n[i] = (inc_n[i] != 2'd0) && (net_n[i] > $signed(SW'(MAX_PEND)));
    end
  end

  assign rsv_ready = ~|over_n;
  assign accept    = rsv_valid && rsv_ready;

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      if (accept) begin
        pend_d[i] = (net_n[i] < 0) ? '0 : net_n[i][CNT_W-1:0];
      end else begin
        pend_d[i] = (drn_n[i] < 0) ? '0 : drn_n[i][CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= (i == SP_ID) ? SP_INIT[DATA_W-1:0] : '0;
        pend_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
        pend_q[i] <= pend_d[i];
      end
    end
  end

  // Read ports.
  logic srcA_ok, srcB_ok;
  assign srcA_ok = (int'(srcA) != NONE_ID) && (int'(srcA) < NREGS);
  assign srcB_ok = (int'(srcB) != NONE_ID) && (int'(srcB) < NREGS);

`ifdef REGFILE_BYPASS_EN
  // Forward the in-flight write (M before E) and treat the operand as ready
  // when this cycle's writes retire every outstanding reservation.
  always_comb begin
    valA = '0;
    rdyA = 1'b1;
    if (srcA_ok) begin
      if (dstM_en && (srcA == dstM))      valA = valM;
      else if (dstE_en && (srcA == dstE)) valA = valE;
      else                                valA = regs_q[srcA];
      rdyA = ({2'b00, pend_q[srcA]} <= {{CNT_W{1'b0}}, dec_n[srcA]});
    end
  end

  always_comb begin
    valB = '0;
    rdyB = 1'b1;
    if (srcB_ok) begin
      if (dstM_en && (srcB == dstM))      valB = valM;
      else if (dstE_en && (srcB == dstE)) valB = valE;
      else                                valB = regs_q[srcB];
      rdyB = ({2'b00, pend_q[srcB]} <= {{CNT_W{1'b0}}, dec_n[srcB]});
    end
  end
`else
  always_comb begin
    valA = '0;
    rdyA = 1'b1;
    if (srcA_ok) begin
      valA = regs_q[srcA];
      rdyA = (pend_q[srcA] == '0);
    end
  end

  always_comb begin
    valB = '0;
    rdyB = 1'b1;
    if (srcB_ok) begin
      valB = regs_q[srcB];
      rdyB = (pend_q[srcB] == '0);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_sb
// Purpose  : directed self-checking bench for regfile_sb (SP_INIT = 0x100).
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  srcA, srcB, dstE, dstM, rsvE, rsvM;
  logic [63:0] valA, valB, valE, valM;
  logic        rdyA, rdyB, rsv_valid, rsv_ready;

  int n_total = 0;
  int n_bad   = 0;

  regfile_sb #(.SP_INIT(64'h100)) u_dut (
    .clk(clk), .rst(rst),
    .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
    .rdyA(rdyA), .rdyB(rdyB),
    .dstE(dstE), .dstM(dstM), .valE(valE), .valM(valM),
    .rsv_valid(rsv_valid), .rsvE(rsvE), .rsvM(rsvM), .rsv_ready(rsv_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    dstE = 4'd15; dstM = 4'd15; valE = '0; valM = '0;
    rsv_valid = 1'b0; rsvE = 4'd15; rsvM = 4'd15;
  endtask

  // Advance one clock, leave inputs to settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; srcA = 4'd0; srcB = 4'd0;
    idle();
    tick();
    rst = 1'b0;

    // Reset state
    srcA = 4'd4; srcB = 4'd3; #1;
    check("rst_sp",    valA, 64'h100);
    check("rst_r3",    valB, 64'h0);
    check("rst_rdyA",  rdyA, 1);
    check("rst_rdyB",  rdyB, 1);
    check("rst_ready", rsv_ready, 1);

    // Dual write to the same register: M wins; writes to 15 are dropped
    dstE = 4'd2; dstM = 4'd2; valE = 64'hAA; valM = 64'hBB;
    tick(); idle();
    srcA = 4'd2; #1;
    check("dual_m_wins", valA, 64'hBB);
    dstE = 4'd15; valE = 64'h123; dstM = 4'd15; valM = 64'h456;
    tick(); idle();
    srcB = 4'd15; #1;
    check("none_reads0", valB, 64'h0);
    check("none_rdy",    rdyB, 1);
    check("r2_kept",     valA, 64'hBB);

    // Reserve 5, then retire it with a write
    rsv_valid = 1'b1; rsvE = 4'd5; #1;
    check("rsv5_ready", rsv_ready, 1);
    tick(); idle();
    srcA = 4'd5; #1;
    check("r5_pending", rdyA, 0);
    dstE = 4'd5; valE = 64'h7; tick(); idle(); #1;
    check("r5_rdy",  rdyA, 1);
    check("r5_val",  valA, 64'h7);

    // Saturation on register 1
    for (int k = 0; k < 3; k++) begin
      rsv_valid = 1'b1; rsvE = 4'd1; #1;
      check("sat_acc", rsv_ready, 1);
      tick();
    end
    #1;
    check("sat_full", rsv_ready, 0);
    tick();                               // refused request
    #1;
    check("sat_still_full", rsv_ready, 0);
    dstE = 4'd1; valE = 64'h9; #1;
    check("sat_net_ready", rsv_ready, 1);
    tick(); idle();                       // +1 -1: stays at 3
    srcA = 4'd1;
    for (int k = 0; k < 2; k++) begin
      dstE = 4'd1; valE = 64'h9; tick(); idle(); #1;
      check("sat_drain_pend", rdyA, 0);
    end
    dstE = 4'd1; valE = 64'h9; tick(); idle(); #1;
    check("sat_drained", rdyA, 1);

    // rsvE == rsvM counts twice
    rsv_valid = 1'b1; rsvE = 4'd8; rsvM = 4'd8; #1;
    check("dbl_ready", rsv_ready, 1);
    tick(); #1;
    check("dbl_over", rsv_ready, 0);      // 2 + 2 > 3
    rsvM = 4'd15; #1;
    check("dbl_plus1", rsv_ready, 1);     // 2 + 1 = 3
    idle();
    dstE = 4'd8; dstM = 4'd8; tick(); idle();
    srcB = 4'd8; #1;
    check("dbl_drained", rdyB, 1);

    // Forwarding behaviour on register 6
    dstE = 4'd6; valE = 64'h33; tick(); idle();
    rsv_valid = 1'b1; rsvE = 4'd6; tick(); idle();
    srcA = 4'd6; dstM = 4'd6; valM = 64'h55; #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_val", valA, 64'h55);
    check("byp_rdy", rdyA, 1);
`else
    check("nobyp_val", valA, 64'h33);
    check("nobyp_rdy", rdyA, 0);
`endif
    tick(); idle(); #1;
    check("r6_written", valA, 64'h55);
    check("r6_rdy",     rdyA, 1);

    // Mid-operation reset
    rsv_valid = 1'b1; rsvE = 4'd9; rsvM = 4'd10; tick(); idle();
    srcA = 4'd9; srcB = 4'd10; #1;
    check("pre_rst_rdyA", rdyA, 0);
    check("pre_rst_rdyB", rdyB, 0);
    rst = 1'b1; rsv_valid = 1'b1; rsvE = 4'd9; dstE = 4'd3; valE = 64'h77;
    tick();
    rst = 1'b0; idle(); #1;
    check("post_rst_rdyA", rdyA, 1);
    check("post_rst_rdyB", rdyB, 1);
    srcA = 4'd3; srcB = 4'd4; #1;
    check("post_rst_wr_drop", valA, 64'h0);
    check("post_rst_sp",      valB, 64'h100);
    srcA = 4'd2; #1;
    check("post_rst_r2", valA, 64'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_sb.md
# regfile_sb

Parametrised successor to the Y86-64 register file, used in the decode/writeback stages of the pipelined core. It provides two combinational read ports and two synchronous write ports (E and M). It adds synchronous reset, a configurable stack-pointer reset value and deterministic same-register write priority. A per-register pending-write scoreboard tells decode whether a read operand is safe to consume.

## Interface
- `DATA_W`, 64, register width in bits
- `NREGS`, 16, number of register slots, including the "none" index
- `ADDR_W`, 4, register index width; must satisfy 2^ADDR_W >= NREGS
- `NONE_ID`, 15, "no register" index; never written, reads as 0, never pending
- `SP_ID`, 4, stack-pointer index
- `SP_INIT`, 0, value loaded into `SP_ID` at reset
- `MAX_PEND`, 3, maximum outstanding reservations per register; counter width is clog2(MAX_PEND+1)
- `clk` in 1: single clock, all state updates on posedge
- `rst` in 1: synchronous, active-high reset
- `srcA`, `srcB` in ADDR_W: read indices
- `valA`, `valB` out DATA_W: read data
- `rdyA`, `rdyB` out 1: operand has no pending write
- `dstE`, `dstM` in ADDR_W: write indices; `NONE_ID` means no write
- `valE`, `valM` in DATA_W: write data
- `rsv_valid` in 1: decode requests reservation of `rsvE`/`rsvM`
- `rsvE`, `rsvM` in ADDR_W: registers to reserve; `NONE_ID` means ignore
- `rsv_ready` out 1: reservation can be accepted this cycle

## Operation
- **Reset** (`rst`=1 at posedge):
  - All registers go to 0, except `SP_ID`, which goes to `SP_INIT`.
  - All pending counters go to 0.
  - Post-reset outputs: `valA`/`valB` = contents of the addressed register, `rdyA`/`rdyB` = 1, `rsv_ready` = 1.
  - Writes and reservations presented in a reset cycle are discarded.
- **Read**:
  - `valX` = `reg[srcX]`.
  - If `srcX` = `NONE_ID` or `srcX` >= `NREGS`: `valX` = 0 and `rdyX` = 1.
  - Otherwise `rdyX` = (`pend[srcX]` == 0).
- **Write** at posedge:
  - `reg[dstE]` <= `valE` when `dstE` != `NONE_ID`.
  - `reg[dstM]` <= `valM` when `dstM` != `NONE_ID`.
  - If `dstE` == `dstM` (not `NONE_ID`), M wins. This matches `popq %rsp` semantics.
- **Scoreboard**:
  - A reservation is accepted when `rsv_valid` && `rsv_ready`.
  - An accepted reservation increments `pend[rsvE]` and `pend[rsvM]`, each by 1 and only if not `NONE_ID`. `rsvE` == `rsvM` increments by 2.
  - Each write port with a non-`NONE_ID` destination decrements `pend[dst]` by 1, saturating at 0.
  - `dstE` == `dstM` decrements by 2, saturating at 0.
  - Simultaneous increment and decrement on the same register apply the net change.
  - `rsv_ready` = 0 when any targeted register would exceed `MAX_PEND` after the net change for this cycle. A refused request changes no counters.
  - Out-of-range indices (>= `NREGS`) are ignored by writes and reservations.

## Timing
- Reads are combinational, with zero latency from `srcX`.
- Without bypass, a write is visible on `valX`/`rdyX` the cycle after its posedge.
- `rsv_ready` is combinational from `rsvE`, `rsvM`, `dstE`, `dstM` and the counters. It must not depend on `rsv_valid`.
- A counter changes only at the posedge.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- **Defined**: write-through forwarding.
  - If `srcX` matches `dstM`, `valX` = `valM`; else if `srcX` matches `dstE`, `valX` = `valE`.
  - In either case, `rdyX` = 1 when `pend[srcX]` equals the decrement this cycle.
- **Undefined**: no forwarding. Reads return only stored state, and `rdyX` reflects counters only.

## Test plan
- **Reset**: `SP_INIT`=0x100, assert `rst` for 1 cycle. Then `srcA`=4 -> `valA`=0x100; `srcB`=3 -> `valB`=0; `rdyA`=`rdyB`=1; `rsv_ready`=1.
- **Dual write, same register**: `dstE`=`dstM`=2, `valE`=0xAA, `valM`=0xBB. Next cycle `srcA`=2 -> `valA`=0xBB. Writing to 15 leaves `srcB`=15 -> `valB`=0.
- **Scoreboard**:
  - Reserve `rsvE`=5 -> next cycle `srcA`=5 gives `rdyA`=0.
  - `dstE`=5 write 0x7 -> following cycle `rdyA`=1, `valA`=0x7.
- **Saturation**:
  - Three accepted reservations on register 1 -> fourth request gives `rsv_ready`=0 and counter stays 3.
  - Same cycle with `dstE`=1 -> `rsv_ready`=1 and counter stays 3.
- **Bypass** (`REGFILE_BYPASS_EN`): `pend[6]`=1, `dstM`=6, `valM`=0x55, `srcA`=6 -> same cycle `valA`=0x55, `rdyA`=1. Without the macro: `valA`=old value, `rdyA`=0.
- **Mid-operation reset**: `rst` asserted with `rsv_valid`=1 and pending counters nonzero -> next cycle all `rdy`=1 and counters 0.
